// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
// Holds the default queue depth, the NOP word presented on an empty queue,
// and the packed queue entry {instr, pc}.
package fetch_pkg;

    localparam int unsigned FETCH_DEPTH_DEFAULT = 2;
    localparam logic [31:0] FETCH_NOP           = 32'h0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used for both the instruction queue and the PC tag FIFO.
// Ports: clk_i/rst_ni (async active-low), push_i/wdata_i, pop_i, flush_i (empties,
// wins over push/pop), rdata_o (head, combinational read), full_o, empty_o, count_o.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Next-state: a push into a full FIFO is accepted when a pop frees the slot the same cycle.
    always_comb begin
        empty_o  = (count_q == '0);
        full_o   = (count_q == CW'(DEPTH));
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues in-order reads at the current PC, pairs each
// response with the PC it was fetched from, and buffers {instr, pc} for decode.
// Ports: clk_i, start_i (async active-low reset / run), pc_i, pcWrite_o, flush_i,
// imem_req_o/imem_addr_o/imem_gnt_i/imem_rvalid_i/imem_rdata_i (memory side),
// inst_valid_o/inst_o/inst_pc_o/inst_ready_i (decode side).
// Optional FETCH_UNIT_PERF_EN adds fetch_cnt_o (pops) and stall_cnt_o (no-request cycles).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_DEPTH_DEFAULT
) (
    input  logic        clk_i,
    input  logic        start_i,
    input  logic [31:0] pc_i,
    output logic        pcWrite_o,
    input  logic        flush_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i
`ifdef FETCH_UNIT_PERF_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o
`endif
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;
    localparam int unsigned EW = $bits(fetch_entry_t);

    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] disc_q, disc_d;
    logic [CW-1:0] q_count, tag_count;
    logic          q_full, q_empty, tag_full, tag_empty;
    logic [EW-1:0] q_rdata;
    logic [31:0]   tag_pc;
    fetch_entry_t  head, push_entry;
    logic          grant, resp_ok, deliver, pop;
    logic [SW-1:0] demand;
    logic          unused_status;

    // Request only if every in-flight and buffered instruction still fits after this cycle's pop.
    always_comb begin
        pop         = inst_valid_o && inst_ready_i;
        demand      = {1'b0, out_q} + {1'b0, q_count} - SW'(pop);
        imem_req_o  = start_i && !flush_i && (demand < SW'(DEPTH));
        imem_addr_o = pc_i;
        grant       = imem_req_o && imem_gnt_i;
        pcWrite_o   = start_i && (grant || flush_i);
        // Responses with nothing outstanding are strays (e.g. from before reset).
        resp_ok     = imem_rvalid_i && (out_q != '0);
        deliver     = resp_ok && !flush_i && (disc_q == '0);
        push_entry  = '{instr: imem_rdata_i, pc: tag_pc};
    end

    // Outstanding and discard counters; a flush marks everything still in flight as stale.
    always_comb begin
        out_d  = out_q + CW'(grant) - CW'(resp_ok);
        disc_d = disc_q;
        if (flush_i) begin
            disc_d = out_q - CW'(resp_ok);
        end else if (resp_ok && (disc_q != '0)) begin
            disc_d = disc_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            out_q  <= '0;
            disc_q <= '0;
        end else begin
            out_q  <= out_d;
            disc_q <= disc_d;
        end
    end

    // PC of each granted request, consumed by its (non-discarded) response.
    fetch_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(32)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_ni  (start_i),
        .push_i  (grant),
        .wdata_i (pc_i),
        .pop_i   (deliver),
        .flush_i (flush_i),
        .rdata_o (tag_pc),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .count_o (tag_count)
    );

    // Instruction queue towards decode.
    fetch_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(EW)
    ) u_inst_queue (
        .clk_i   (clk_i),
        .rst_ni  (start_i),
        .push_i  (deliver),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .flush_i (flush_i),
        .rdata_o (q_rdata),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    // Head presentation; NOP with PC 0 when the queue is empty.
    always_comb begin
        head         = fetch_entry_t'(q_rdata);
        inst_valid_o = !q_empty;
        inst_o       = inst_valid_o ? head.instr : FETCH_NOP;
        inst_pc_o    = inst_valid_o ? head.pc : 32'h0;
    end

    assign unused_status = ^{tag_full, tag_empty, tag_count, q_full};

`ifdef FETCH_UNIT_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Free-running counters, wrapping at 2^32.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + 32'(pop && !flush_i);
        stall_cnt_d = stall_cnt_q + 32'(start_i && !flush_i && !imem_req_o);
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (DEPTH=2) plus a direct check of fetch_fifo
// behaviour when full with simultaneous push and pop.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] I0 = 32'h0010_0093, I1 = 32'h0020_0113;
    localparam logic [31:0] I2 = 32'h0030_0193, I3 = 32'h0040_0213;
    localparam logic [31:0] J0 = 32'h1111_0001, J1 = 32'h1111_0002, J2 = 32'h1111_0003;
    localparam logic [31:0] K0 = 32'h2222_0001, L0 = 32'h3333_0001;

    logic        clk_i = 1'b0;
    logic        start_i, flush_i, imem_gnt_i, imem_rvalid_i, inst_ready_i;
    logic [31:0] pc_i, imem_rdata_i;
    logic        pcWrite_o, imem_req_o, inst_valid_o;
    logic [31:0] imem_addr_o, inst_o, inst_pc_o;
`ifdef FETCH_UNIT_PERF_EN
    logic [31:0] fetch_cnt_o, stall_cnt_o;
    logic        pend;
`endif

    logic       f_rst_n, f_push, f_pop, f_flush, f_full, f_empty;
    logic [7:0] f_wdata, f_rdata;
    logic [1:0] f_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    fetch_unit #(.DEPTH(2)) dut (
        .clk_i         (clk_i),
        .start_i       (start_i),
        .pc_i          (pc_i),
        .pcWrite_o     (pcWrite_o),
        .flush_i       (flush_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_ready_i  (inst_ready_i)
`ifdef FETCH_UNIT_PERF_EN
        ,
        .fetch_cnt_o   (fetch_cnt_o),
        .stall_cnt_o   (stall_cnt_o)
`endif
    );

    fetch_fifo #(.DEPTH(2), .WIDTH(8)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (f_rst_n),
        .push_i  (f_push),
        .wdata_i (f_wdata),
        .pop_i   (f_pop),
        .flush_i (f_flush),
        .rdata_o (f_rdata),
        .full_o  (f_full),
        .empty_o (f_empty),
        .count_o (f_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic gnt, input logic rv,
                         input logic [31:0] rd, input logic rdy, input logic fl);
        pc_i          = pc;
        imem_gnt_i    = gnt;
        imem_rvalid_i = rv;
        imem_rdata_i  = rd;
        inst_ready_i  = rdy;
        flush_i       = fl;
        #1;
    endtask

    task automatic chk_fetch(input string tag, input logic req, input logic pcw);
        chk({tag, ".req"}, 32'(imem_req_o), 32'(req));
        chk({tag, ".pcw"}, 32'(pcWrite_o), 32'(pcw));
    endtask

    task automatic chk_head(input string tag, input logic v, input logic [31:0] ins,
                            input logic [31:0] pc);
        chk({tag, ".valid"}, 32'(inst_valid_o), 32'(v));
        chk({tag, ".inst"}, inst_o, ins);
        chk({tag, ".pc"}, inst_pc_o, pc);
    endtask

    task automatic restart();
        start_i = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        start_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        start_i = 1'b0;
        f_rst_n = 1'b0; f_push = 1'b0; f_pop = 1'b0; f_flush = 1'b0; f_wdata = 8'h0;
        // Reset held while the environment is busy: everything must stay quiet.
        drive(32'h40, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
        tick(); tick();
        chk_fetch("rst", 1'b0, 1'b0);
        chk_head("rst", 1'b0, 32'h0, 32'h0);
        chk("rst.addr", imem_addr_o, 32'h40);
        start_i = 1'b1;
        f_rst_n = 1'b1;

        // Streaming with 1-cycle memory and decode always ready.
        drive(32'h0,  1'b1, 1'b0, 32'h0, 1'b1, 1'b0); chk_fetch("s1c0", 1'b1, 1'b1);
        chk("s1c0.addr", imem_addr_o, 32'h0); chk_head("s1c0", 1'b0, 32'h0, 32'h0); tick();
        drive(32'h4,  1'b1, 1'b1, I0, 1'b1, 1'b0); chk_fetch("s1c1", 1'b1, 1'b1);
        chk("s1c1.addr", imem_addr_o, 32'h4); chk_head("s1c1", 1'b0, 32'h0, 32'h0); tick();
        drive(32'h8,  1'b1, 1'b1, I1, 1'b1, 1'b0); chk_fetch("s1c2", 1'b1, 1'b1);
        chk_head("s1c2", 1'b1, I0, 32'h0); tick();
        drive(32'hC,  1'b1, 1'b1, I2, 1'b1, 1'b0); chk_fetch("s1c3", 1'b1, 1'b1);
        chk_head("s1c3", 1'b1, I1, 32'h4); tick();
        drive(32'h10, 1'b0, 1'b1, I3, 1'b1, 1'b0); chk_fetch("s1c4", 1'b1, 1'b0);
        chk_head("s1c4", 1'b1, I2, 32'h8); tick();
        drive(32'h10, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0); chk_head("s1c5", 1'b1, I3, 32'hC); tick();
        chk_head("s1c6", 1'b0, 32'h0, 32'h0);

        // Decode stalled: two grants fill the window, then no request until a pop.
        restart();
        drive(32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0); chk_fetch("s2c0", 1'b1, 1'b1); tick();
        drive(32'h104, 1'b1, 1'b1, J0, 1'b0, 1'b0); chk_fetch("s2c1", 1'b1, 1'b1); tick();
        drive(32'h108, 1'b1, 1'b1, J1, 1'b0, 1'b0); chk_fetch("s2c2", 1'b0, 1'b0);
        chk_head("s2c2", 1'b1, J0, 32'h100); tick();
        drive(32'h108, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0); chk_fetch("s2c3", 1'b0, 1'b0);
        chk_head("s2c3", 1'b1, J0, 32'h100); tick();
        drive(32'h108, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0); chk_fetch("s2c4", 1'b1, 1'b1); tick();
        drive(32'h10C, 1'b0, 1'b1, J2, 1'b1, 1'b0); chk_head("s2c5", 1'b1, J1, 32'h104); tick();
        drive(32'h10C, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0); chk_head("s2c6", 1'b1, J2, 32'h108); tick();
        chk_head("s2c7", 1'b0, 32'h0, 32'h0);

        // Flush with two responses still in flight: both dropped, redirect PC tagged.
        restart();
        drive(32'h200, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0); chk_fetch("s3c0", 1'b1, 1'b1); tick();
        drive(32'h204, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0); chk_fetch("s3c1", 1'b1, 1'b1); tick();
        drive(32'h208, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0); chk_fetch("s3c2", 1'b0, 1'b0); tick();
        drive(32'h208, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1); chk_fetch("s3fl", 1'b0, 1'b1); tick();
        drive(32'h300, 1'b1, 1'b1, 32'hDEAD_0001, 1'b1, 1'b0); chk_fetch("s3c4", 1'b0, 1'b0);
        chk_head("s3c4", 1'b0, 32'h0, 32'h0); tick();
        drive(32'h300, 1'b1, 1'b1, 32'hDEAD_0002, 1'b1, 1'b0); chk_fetch("s3c5", 1'b1, 1'b1);
        chk_head("s3c5", 1'b0, 32'h0, 32'h0); tick();
        drive(32'h304, 1'b0, 1'b1, K0, 1'b1, 1'b0); chk_head("s3c6", 1'b0, 32'h0, 32'h0); tick();
        drive(32'h304, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0); chk_head("s3c7", 1'b1, K0, 32'h300); tick();
        chk_head("s3c8", 1'b0, 32'h0, 32'h0);

        // Response arriving in the flush cycle is dropped and not counted for discard.
        drive(32'h400, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0); chk_fetch("s4c0", 1'b1, 1'b1); tick();
        drive(32'h404, 1'b1, 1'b1, 32'hDEAD_0003, 1'b1, 1'b1); chk_fetch("s4fl", 1'b0, 1'b1); tick();
        drive(32'h500, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0); chk_fetch("s4c2", 1'b1, 1'b1);
        chk_head("s4c2", 1'b0, 32'h0, 32'h0); tick();
        drive(32'h504, 1'b0, 1'b1, L0, 1'b1, 1'b0); chk_head("s4c3", 1'b0, 32'h0, 32'h0); tick();
        drive(32'h504, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0); chk_head("s4c4", 1'b1, L0, 32'h500); tick();
        chk_head("s4c5", 1'b0, 32'h0, 32'h0);

        // Reset with one request outstanding; the late response must be ignored.
        restart();
        drive(32'h700, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0); chk_fetch("s5c0", 1'b1, 1'b1); tick();
        drive(32'h704, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        start_i = 1'b0; #1;
        chk_fetch("s5rst", 1'b0, 1'b0); chk_head("s5rst", 1'b0, 32'h0, 32'h0); tick();
        start_i = 1'b1;
        drive(32'h704, 1'b0, 1'b1, 32'hBAD0_BAD0, 1'b1, 1'b0); chk_fetch("s5c2", 1'b1, 1'b0); tick();
        drive(32'h704, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0); chk_head("s5c3", 1'b0, 32'h0, 32'h0); tick();
        chk_head("s5c4", 1'b0, 32'h0, 32'h0);

        // Full FIFO with push and pop together: count stays 2, order kept.
        f_push = 1'b1; f_wdata = 8'hA1; tick();
        f_wdata = 8'hB2; tick();
        chk("fifo.full", 32'(f_full), 32'd1); chk("fifo.cnt2", 32'(f_count), 32'd2);
        f_wdata = 8'hC3; f_pop = 1'b1; #1;
        chk("fifo.head0", 32'(f_rdata), 32'hA1); tick();
        chk("fifo.cnt_pp", 32'(f_count), 32'd2); chk("fifo.head1", 32'(f_rdata), 32'hB2);
        f_push = 1'b0; tick();
        chk("fifo.head2", 32'(f_rdata), 32'hC3); chk("fifo.cnt1", 32'(f_count), 32'd1); tick();
        f_pop = 1'b0;
        chk("fifo.empty", 32'(f_empty), 32'd1);

`ifdef FETCH_UNIT_PERF_EN
        // Four no-request cycles and ten pops; a refused grant alone is not a stall.
        restart(); #1;
        chk("perf.rst.fetch", fetch_cnt_o, 32'd0); chk("perf.rst.stall", stall_cnt_o, 32'd0);
        drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0); tick();
        drive(32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0); tick();
        drive(32'h4, 1'b1, 1'b1, 32'h13, 1'b0, 1'b0); tick();
        drive(32'h8, 1'b1, 1'b1, 32'h13, 1'b0, 1'b0); tick();
        repeat (3) begin
            drive(32'h8, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0); tick();
        end
        pend = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(32'h8, 1'b1, pend, 32'h13, 1'b1, 1'b0);
            pend = imem_req_o && imem_gnt_i;
            tick();
        end
        drive(32'h8, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("perf.fetch", fetch_cnt_o, 32'd10);
        chk("perf.stall", stall_cnt_o, 32'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
